// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
// Sequencing FSM for the MM:SS countdown timer. Drives the cascaded BCD digit
// counters (load / count-enable / clear), derives the count tick from the
// board clock, handles start/pause/load buttons and drives the alarm LED.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to make an expired timer
// re-arm itself through LOAD instead of clearing back to IDLE.
module countdown_timer_ctrl #(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_HZ     = 1,
    parameter int ALARM_TICKS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start_btn,
    input  logic        i_pause_btn,
    input  logic        i_load_btn,
    input  logic [15:0] i_digits,
    input  logic        i_data_err,
    output logic        o_cnt_load,
    output logic        o_cnt_ce,
    output logic        o_cnt_clr,
    output logic        o_alarm,
    output logic        o_running,
    output logic [2:0]  o_state
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ARMED = 3'd3,
        S_RUN   = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_start_q;
    logic            r_pause_q;
    logic            r_load_q;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [AW-1:0]   r_alarm_cnt;
    logic [AW-1:0]   w_alarm_cnt_nxt;
    logic            r_cnt_load;
    logic            r_cnt_clr;
    logic            r_alarm;
    logic            r_running;
    logic            w_alarm_nxt;
    logic            w_clr_req;
    logic            w_start_edge;
    logic            w_pause_edge;
    logic            w_load_edge;
    logic            w_tick;
    logic            w_digits_zero;

    assign w_start_edge  = i_start_btn & ~r_start_q;
    assign w_pause_edge  = i_pause_btn & ~r_pause_q;
    assign w_load_edge   = i_load_btn  & ~r_load_q;
    assign w_tick        = (r_presc == PRESC_MAX);
    assign w_digits_zero = (i_digits == 16'd0);

    // Next-state decode; a load edge overrides everything outside LOAD/CHECK.
    always_comb begin
        w_next    = r_state;
        w_clr_req = 1'b0;
        if (w_load_edge && (r_state != S_LOAD) && (r_state != S_CHECK)) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_LOAD:  w_next = S_CHECK;
                S_CHECK: begin
                    if (i_data_err) begin
                        w_next = S_ERR;
                    end else if (w_digits_zero) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_start_edge) begin
                        w_next = S_RUN;
                    end else begin
                        w_next = S_ARMED;
                    end
                end
                S_RUN: begin
                    if (w_digits_zero) begin
                        w_next = S_DONE;
                    end else if (w_pause_edge) begin
                        w_next = S_PAUSE;
                    end else begin
                        w_next = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (w_start_edge || w_pause_edge) begin
                        w_next = S_RUN;
                    end else begin
                        w_next = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if ((r_alarm_cnt == ALARM_MAX) || w_start_edge) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        w_next    = S_LOAD;
                        w_clr_req = 1'b0;
`else
                        w_next    = S_IDLE;
                        w_clr_req = 1'b1;
`endif
                    end else begin
                        w_next = S_DONE;
                    end
                end
                S_ERR:   w_next = S_ERR;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Prescaler free-runs while a tick is needed, freezes in PAUSE, else sits at zero.
    always_comb begin
        w_presc_nxt = r_presc;
        case (r_state)
            S_RUN, S_DONE, S_ERR: begin
                if (w_tick) begin
                    w_presc_nxt = {PW{1'b0}};
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            S_PAUSE: w_presc_nxt = r_presc;
            default: w_presc_nxt = {PW{1'b0}};
        endcase
    end

    // Alarm tick counter (DONE only) and alarm LED next value (steady in DONE, blinking in ERR).
    always_comb begin
        if (w_next != S_DONE) begin
            w_alarm_cnt_nxt = {AW{1'b0}};
        end else if ((r_state == S_DONE) && w_tick && (r_alarm_cnt != ALARM_MAX)) begin
            w_alarm_cnt_nxt = r_alarm_cnt + AW'(1);
        end else begin
            w_alarm_cnt_nxt = r_alarm_cnt;
        end
        case (w_next)
            S_DONE: w_alarm_nxt = 1'b1;
            S_ERR: begin
                if (r_state == S_ERR) begin
                    w_alarm_nxt = r_alarm ^ w_tick;
                end else begin
                    w_alarm_nxt = 1'b0;
                end
            end
            default: w_alarm_nxt = 1'b0;
        endcase
    end

    // State register and button edge-detector flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_pause_q <= 1'b0;
            r_load_q  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= i_start_btn;
            r_pause_q <= i_pause_btn;
            r_load_q  <= i_load_btn;
        end
    end

    // Prescaler and alarm tick counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= {PW{1'b0}};
            r_alarm_cnt <= {AW{1'b0}};
        end else begin
            r_presc     <= w_presc_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
        end
    end

    // Registered outputs, aligned with the state they belong to; clear held during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_load <= 1'b0;
            r_cnt_clr  <= 1'b1;
            r_alarm    <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_cnt_load <= (w_next == S_LOAD);
            r_cnt_clr  <= w_clr_req;
            r_alarm    <= w_alarm_nxt;
            r_running  <= (w_next == S_RUN);
        end
    end

    // Count enable is the only decoded output: one pulse per tick in RUN, never at 00:00.
    assign o_cnt_ce   = (r_state == S_RUN) && w_tick && !w_digits_zero;
    assign o_cnt_load = r_cnt_load;
    assign o_cnt_clr  = r_cnt_clr;
    assign o_alarm    = r_alarm;
    assign o_running  = r_running;
    assign o_state    = r_state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Testbench for countdown_timer_ctrl with CLK_HZ=10, TICK_HZ=1 (DIV=10), ALARM_TICKS=2.
// A small BCD counter-chain model closes the loop on digits; expected outputs are
// queued per cycle when stimulus is applied and compared on the falling edge.
module tb_countdown_timer_ctrl;
    localparam int SIG_STATE = 0;
    localparam int SIG_LOAD  = 1;
    localparam int SIG_CE    = 2;
    localparam int SIG_CLR   = 3;
    localparam int SIG_ALARM = 4;
    localparam int SIG_RUN   = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start_btn;
    logic        pause_btn;
    logic        load_btn;
    logic        data_err;
    logic [15:0] m_digits;
    logic [15:0] sw_val;
    logic        o_cnt_load;
    logic        o_cnt_ce;
    logic        o_cnt_clr;
    logic        o_alarm;
    logic        o_running;
    logic [2:0]  o_state;

    int   cyc     = 0;
    int   n_check = 0;
    int   n_pass  = 0;
    exp_t sb[$];
    exp_t mon_e;

    countdown_timer_ctrl #(
        .CLK_HZ(10),
        .TICK_HZ(1),
        .ALARM_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start_btn(start_btn),
        .i_pause_btn(pause_btn),
        .i_load_btn(load_btn),
        .i_digits(m_digits),
        .i_data_err(data_err),
        .o_cnt_load(o_cnt_load),
        .o_cnt_ce(o_cnt_ce),
        .o_cnt_clr(o_cnt_clr),
        .o_alarm(o_alarm),
        .o_running(o_running),
        .o_state(o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = r[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Digit counter chain model: clear, load from switches, or decrement on ce.
    initial m_digits = 16'h0000;
    always @(posedge clk) begin
        if (o_cnt_clr) m_digits <= 16'h0000;
        else if (o_cnt_load) m_digits <= sw_val;
        else if (o_cnt_ce) m_digits <= bcd_dec(m_digits);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_check++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_STATE: return {29'd0, o_state};
            SIG_LOAD:  return {31'd0, o_cnt_load};
            SIG_CE:    return {31'd0, o_cnt_ce};
            SIG_CLR:   return {31'd0, o_cnt_clr};
            SIG_ALARM: return {31'd0, o_alarm};
            SIG_RUN:   return {31'd0, o_running};
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic void sb_push(input int c, input int sig, input logic [31:0] v, input string tag);
        exp_t e;
        int   idx;
        e.cyc = c; e.sig = sig; e.val = v; e.tag = tag;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    // Scoreboard: pop every expectation due this cycle and compare on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_val(mon_e.tag, observe(mon_e.sig), mon_e.val);
        end
    end

    task automatic press(input logic s, input logic p, input logic l, input int hold);
        start_btn = s; pause_btn = p; load_btn = l;
        repeat (hold) @(negedge clk);
        start_btn = 1'b0; pause_btn = 1'b0; load_btn = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        int n, m, r, ntog, last;
        logic prev;
        reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; load_btn = 1'b0;
        data_err = 1'b0; sw_val = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_state", {29'd0, o_state}, 32'd0);
        check_val("rst_clr", {31'd0, o_cnt_clr}, 32'd1);
        check_val("rst_load", {31'd0, o_cnt_load}, 32'd0);
        check_val("rst_ce", {31'd0, o_cnt_ce}, 32'd0);
        check_val("rst_alarm", {31'd0, o_alarm}, 32'd0);
        check_val("rst_running", {31'd0, o_running}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_release_clr", {31'd0, o_cnt_clr}, 32'd0);

        // Load 00:03
        sw_val = 16'h0003; n = cyc;
        sb_push(n + 1, SIG_STATE, 32'd1, "ld_state_load");
        sb_push(n + 1, SIG_LOAD, 32'd1, "ld_cnt_load");
        sb_push(n + 2, SIG_STATE, 32'd2, "ld_state_check");
        sb_push(n + 2, SIG_LOAD, 32'd0, "ld_cnt_load_off");
        sb_push(n + 3, SIG_STATE, 32'd3, "ld_state_armed");
        for (int k = 1; k <= 5; k++) sb_push(n + k, SIG_CE, 32'd0, "ld_ce");
        press(1'b0, 1'b0, 1'b1, 1);
        wait_until(n + 6);

        // Run to expiry
        n = cyc;
        for (int k = 1; k <= 31; k++) begin
            sb_push(n + k, SIG_CE, (k % 10 == 0) ? 32'd1 : 32'd0, "run_ce");
            sb_push(n + k, SIG_RUN, 32'd1, "run_running");
        end
        sb_push(n + 1, SIG_STATE, 32'd4, "run_state");
        sb_push(n + 31, SIG_STATE, 32'd4, "run_state_last");
        sb_push(n + 31, SIG_ALARM, 32'd0, "run_alarm_off");
        for (int k = 32; k <= 51; k++) begin
            sb_push(n + k, SIG_STATE, 32'd6, "done_state");
            sb_push(n + k, SIG_ALARM, 32'd1, "done_alarm");
            sb_push(n + k, SIG_CE, 32'd0, "done_ce");
            sb_push(n + k, SIG_RUN, 32'd0, "done_running");
        end
        sb_push(n + 52, SIG_ALARM, 32'd0, "done_alarm_end");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        sb_push(n + 52, SIG_STATE, 32'd1, "reload_state_load");
        sb_push(n + 52, SIG_LOAD, 32'd1, "reload_cnt_load");
        sb_push(n + 52, SIG_CLR, 32'd0, "reload_no_clr");
        sb_push(n + 53, SIG_CLR, 32'd0, "reload_no_clr2");
        sb_push(n + 53, SIG_STATE, 32'd2, "reload_state_check");
        sb_push(n + 54, SIG_STATE, 32'd3, "reload_state_armed");
`else
        sb_push(n + 52, SIG_STATE, 32'd0, "exp_state_idle");
        sb_push(n + 52, SIG_CLR, 32'd1, "exp_clr_pulse");
        sb_push(n + 53, SIG_CLR, 32'd0, "exp_clr_end");
        sb_push(n + 53, SIG_STATE, 32'd0, "exp_state_idle2");
`endif
        press(1'b1, 1'b0, 1'b0, 1);
        wait_until(n + 56);

        // Pause / resume, coincident edges, reset mid-RUN
        sw_val = 16'h0005; n = cyc;
        sb_push(n + 1, SIG_STATE, 32'd1, "pr_state_load");
        sb_push(n + 3, SIG_STATE, 32'd3, "pr_state_armed");
        press(1'b0, 1'b0, 1'b1, 1);
        wait_until(n + 5);
        n = cyc; m = n + 14; r = m + 51;
        sb_push(n + 1, SIG_STATE, 32'd4, "pr_state_run");
        for (int k = 1; k <= 14; k++) sb_push(n + k, SIG_CE, (k == 10) ? 32'd1 : 32'd0, "pr_ce_pre");
        for (int c = m + 1; c <= r; c++) begin
            sb_push(c, SIG_STATE, 32'd5, "pr_state_pause");
            sb_push(c, SIG_CE, 32'd0, "pr_ce_paused");
            sb_push(c, SIG_RUN, 32'd0, "pr_running_paused");
        end
        sb_push(r + 1, SIG_STATE, 32'd4, "pr_state_resume");
        for (int k = 1; k <= 6; k++) begin
            sb_push(r + k, SIG_CE, (k == 6) ? 32'd1 : 32'd0, "pr_ce_resume");
            sb_push(r + k, SIG_RUN, 32'd1, "pr_running_resume");
        end
        for (int c = r + 7; c <= r + 16; c++) sb_push(c, SIG_CE, 32'd0, "sim_ce");
        sb_push(r + 9, SIG_STATE, 32'd5, "sim_pause_wins");
        sb_push(r + 9, SIG_RUN, 32'd0, "sim_running");
        for (int c = r + 13; c <= r + 15; c++) sb_push(c, SIG_STATE, 32'd4, "sim_state_run");
        sb_push(r + 16, SIG_STATE, 32'd0, "rst_run_state");
        sb_push(r + 16, SIG_CLR, 32'd1, "rst_run_clr");
        sb_push(r + 16, SIG_RUN, 32'd0, "rst_run_running");
        sb_push(r + 16, SIG_ALARM, 32'd0, "rst_run_alarm");
        sb_push(r + 17, SIG_CLR, 32'd0, "rst_run_clr_end");
        sb_push(r + 17, SIG_STATE, 32'd0, "rst_run_state2");
        press(1'b1, 1'b0, 1'b0, 1);
        wait_until(m);
        press(1'b0, 1'b1, 1'b0, 3);
        wait_until(r);
        press(1'b0, 1'b1, 1'b0, 1);
        wait_until(r + 8);
        press(1'b1, 1'b1, 1'b0, 1);
        wait_until(r + 12);
        press(1'b1, 1'b0, 1'b0, 1);
        wait_until(r + 15);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_until(r + 18);

        // Invalid load -> ERR, blinking alarm, start ignored
        data_err = 1'b1; sw_val = 16'h00A0; n = cyc;
        sb_push(n + 1, SIG_STATE, 32'd1, "err_state_load");
        sb_push(n + 2, SIG_STATE, 32'd2, "err_state_check");
        sb_push(n + 3, SIG_STATE, 32'd7, "err_state");
        press(1'b0, 1'b0, 1'b1, 1);
        wait_until(n + 3);
        prev = o_alarm; ntog = 0; last = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) start_btn = 1'b1;
            if (i == 6) start_btn = 1'b0;
            @(negedge clk);
            if (o_alarm !== prev) begin
                ntog++;
                if (last >= 0) check_val("err_blink_period", cyc - last, 32'd10);
                last = cyc;
            end
            prev = o_alarm;
        end
        check_val("err_toggle_count", ntog, 32'd4);
        check_val("err_state_hold", {29'd0, o_state}, 32'd7);

        // Recover with a valid load
        data_err = 1'b0; sw_val = 16'h0010; n = cyc;
        sb_push(n + 1, SIG_STATE, 32'd1, "rec_state_load");
        sb_push(n + 1, SIG_LOAD, 32'd1, "rec_cnt_load");
        sb_push(n + 2, SIG_STATE, 32'd2, "rec_state_check");
        sb_push(n + 3, SIG_STATE, 32'd3, "rec_state_armed");
        sb_push(n + 3, SIG_ALARM, 32'd0, "rec_alarm_off");
        press(1'b0, 1'b0, 1'b1, 1);
        wait_until(n + 4);

        // Zero load with coincident start (load wins), then start ignored in IDLE
        sw_val = 16'h0000; n = cyc;
        sb_push(n + 1, SIG_STATE, 32'd1, "zero_load_prio");
        sb_push(n + 1, SIG_RUN, 32'd0, "zero_running");
        sb_push(n + 2, SIG_STATE, 32'd2, "zero_state_check");
        sb_push(n + 3, SIG_STATE, 32'd0, "zero_state_idle");
        press(1'b1, 1'b0, 1'b1, 1);
        wait_until(n + 5);
        n = cyc;
        for (int k = 1; k <= 3; k++) begin
            sb_push(n + k, SIG_STATE, 32'd0, "idle_start_ignored");
            sb_push(n + k, SIG_RUN, 32'd0, "idle_running");
            sb_push(n + k, SIG_CE, 32'd0, "idle_ce");
        end
        press(1'b1, 1'b0, 1'b0, 1);
        wait_until(n + 5);

        check_val("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule
